// File: rtl/set_assoc_cache_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared op encodings, sweep FSM states and width helpers for the
//            set-associative cache core.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_INVAL = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;

   // Never returns zero so that degenerate parameters still yield legal vectors.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byte_en);
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (byte_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/set_assoc_cache_core_lru_ages.sv
`default_nettype none
// ============================================================================
// Module   : cache_lru_ages
// Brief    : Combinational true-LRU helper: picks hit or victim way for one set
//            and produces the age vector after touching that way.
// Revision : 1.0 - initial release
// ============================================================================
module cache_lru_ages #(
   parameter int WAYS  = 4,
   parameter int WAY_W = 2
)(
   input  logic [WAYS*WAY_W-1:0] ages,
   input  logic [WAYS-1:0]       hit_vec,
   input  logic [WAYS-1:0]       valid_vec,
   output logic                  hit,
   output logic [WAY_W-1:0]      sel_way,
   output logic [WAYS*WAY_W-1:0] ages_next
);

   logic [WAY_W-1:0] w_hit_way;
   logic [WAY_W-1:0] w_victim;
   logic [WAY_W-1:0] w_touched_age;

   always_comb begin
      hit       = |hit_vec;
      w_hit_way = '0;
      w_victim  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_vec[w]) w_hit_way = WAY_W'(w);
      end
      for (int w = 1; w < WAYS; w++) begin
         if (ages[w*WAY_W +: WAY_W] > ages[w_victim*WAY_W +: WAY_W]) w_victim = WAY_W'(w);
      end
      // Descending scan so the lowest-index invalid way wins over the oldest way.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_vec[w]) w_victim = WAY_W'(w);
      end
      sel_way       = hit ? w_hit_way : w_victim;
      w_touched_age = ages[sel_way*WAY_W +: WAY_W];
      ages_next     = ages;
      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == sel_way)
            ages_next[w*WAY_W +: WAY_W] = '0;
         else if (ages[w*WAY_W +: WAY_W] < w_touched_age)
            ages_next[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/set_assoc_cache_core.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache_core
// Brief    : N-way write-back L1 cache array: registered lookup, true-LRU,
//            fills and an invalidate-all sweep. CACHE_STATS_EN adds hit/miss
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache_core
   import cache_pkg::*;
#(
   parameter  int WAYS       = 4,
   parameter  int SETS       = 128,
   parameter  int LINE_WORDS = 8,
   localparam int WAY_W      = clog2_min1(WAYS),
   localparam int WORD_W     = clog2_min1(LINE_WORDS),
   localparam int OFF_W      = WORD_W + 2,
   localparam int IDX_W      = clog2_min1(SETS),
   localparam int TAG_W      = 32 - IDX_W - OFF_W,
   localparam int LINE_W     = 32 * LINE_WORDS
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_byte_en,
   input  logic [LINE_W-1:0] req_line,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [WAY_W-1:0]  resp_way,
   output logic              resp_dirty,
   output logic              resp_lvalid,
   output logic [TAG_W-1:0]  resp_tag,
   output logic [31:0]       resp_data,
   output logic [LINE_W-1:0] resp_line
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses
`endif
);

   function automatic logic [WAYS*WAY_W-1:0] age_init();
      logic [WAYS*WAY_W-1:0] v;
      v = '0;
      for (int w = 0; w < WAYS; w++) v[w*WAY_W +: WAY_W] = WAY_W'(w);
      return v;
   endfunction

   localparam logic [WAYS*WAY_W-1:0] C_AGE_INIT = age_init();

   logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
   logic [LINE_W-1:0]     r_data  [SETS][WAYS];
   logic [WAYS-1:0]       r_valid [SETS];
   logic [WAYS-1:0]       r_dirty [SETS];
   logic [WAYS*WAY_W-1:0] r_age   [SETS];

   sweep_state_t          r_state, w_state_next;
   logic [IDX_W-1:0]      r_sweep_idx, w_sweep_idx_next;
   logic                  w_sweep_done;

   logic [TAG_W-1:0]      w_tag;
   logic [IDX_W-1:0]      w_idx;
   logic [WORD_W-1:0]     w_word;
   logic                  w_fire, w_is_read, w_is_write, w_is_fill, w_is_inval;
   logic [WAYS-1:0]       w_hit_vec, w_valid_vec;
   logic                  w_hit;
   logic [WAY_W-1:0]      w_sel_way;
   logic [WAYS*WAY_W-1:0] w_ages_next;
   logic [LINE_W-1:0]     w_sel_line, w_new_line;
   logic [31:0]           w_sel_word, w_base_word;
   logic                  w_merge, w_line_we, w_touch;
   logic                  w_unused;

   assign w_tag       = req_addr[31 -: TAG_W];
   assign w_idx       = req_addr[OFF_W +: IDX_W];
   assign w_word      = req_addr[2 +: WORD_W];
   assign w_unused    = ^req_addr[1:0];

   assign req_ready   = (r_state == ST_IDLE);
   assign w_fire      = req_valid && req_ready;
   assign w_is_read   = (req_op == OP_READ);
   assign w_is_write  = (req_op == OP_WRITE);
   assign w_is_fill   = (req_op == OP_FILL);
   assign w_is_inval  = (req_op == OP_INVAL);
   assign w_valid_vec = r_valid[w_idx];

   for (genvar gw = 0; gw < WAYS; gw++) begin : g_hit
      assign w_hit_vec[gw] = r_valid[w_idx][gw] && (r_tag[w_idx][gw] == w_tag);
   end

   cache_lru_ages #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lru (
      .ages      (r_age[w_idx]),
      .hit_vec   (w_hit_vec),
      .valid_vec (w_valid_vec),
      .hit       (w_hit),
      .sel_way   (w_sel_way),
      .ages_next (w_ages_next)
   );

   assign w_sel_line = r_data[w_idx][w_sel_way];
   assign w_sel_word = w_sel_line[32*w_word +: 32];
   assign w_merge    = (w_is_write && w_hit) || (w_is_fill && (req_byte_en != 4'b0000));
   assign w_line_we  = w_fire && (w_is_fill || (w_is_write && w_hit));
   assign w_touch    = w_fire && (w_is_fill || ((w_is_read || w_is_write) && w_hit));

   // A fill with byte enables is a write-allocate: the store lands on the new line.
   always_comb begin
      w_new_line  = w_is_fill ? req_line : w_sel_line;
      w_base_word = w_is_fill ? req_line[32*w_word +: 32] : w_sel_word;
      if (w_merge) w_new_line[32*w_word +: 32] = merge_word(w_base_word, req_wdata, req_byte_en);
   end

   always_ff @(posedge clk) begin
      if (w_line_we) begin
         r_data[w_idx][w_sel_way] <= w_new_line;
         if (w_is_fill) r_tag[w_idx][w_sel_way] <= w_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_age[s]   <= C_AGE_INIT;
         end
      end else if (r_state == ST_SWEEP) begin
         r_valid[r_sweep_idx] <= '0;
         r_dirty[r_sweep_idx] <= '0;
         r_age[r_sweep_idx]   <= C_AGE_INIT;
      end else if (w_fire) begin
         if (w_touch) r_age[w_idx] <= w_ages_next;
         if (w_is_fill) begin
            r_valid[w_idx][w_sel_way] <= 1'b1;
            r_dirty[w_idx][w_sel_way] <= (req_byte_en != 4'b0000);
         end else if (w_is_write && w_hit) begin
            r_dirty[w_idx][w_sel_way] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_sweep_idx <= '0;
      end else begin
         r_state     <= w_state_next;
         r_sweep_idx <= w_sweep_idx_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_sweep_idx_next = r_sweep_idx;
      w_sweep_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fire && w_is_inval) begin
               w_state_next     = ST_SWEEP;
               w_sweep_idx_next = '0;
            end
         end
         ST_SWEEP: begin
            w_sweep_idx_next = r_sweep_idx + 1'b1;
            if (r_sweep_idx == IDX_W'(SETS - 1)) begin
               w_state_next = ST_IDLE;
               w_sweep_done = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Response reports the selected way as it was before this request's update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid  <= 1'b0;
         resp_hit    <= 1'b0;
         resp_way    <= '0;
         resp_dirty  <= 1'b0;
         resp_lvalid <= 1'b0;
         resp_tag    <= '0;
         resp_data   <= '0;
         resp_line   <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (w_sweep_done) begin
            resp_valid  <= 1'b1;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_dirty  <= 1'b0;
            resp_lvalid <= 1'b0;
            resp_tag    <= '0;
            resp_data   <= '0;
            resp_line   <= '0;
         end else if (w_fire && !w_is_inval) begin
            resp_valid  <= 1'b1;
            resp_hit    <= w_hit;
            resp_way    <= w_sel_way;
            resp_dirty  <= r_dirty[w_idx][w_sel_way];
            resp_lvalid <= w_valid_vec[w_sel_way];
            resp_tag    <= r_tag[w_idx][w_sel_way];
            resp_data   <= w_sel_word;
            resp_line   <= w_sel_line;
         end
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] r_stat_hits, r_stat_misses;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else if (w_fire && w_is_inval) begin
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else if (w_fire && (w_is_read || w_is_write)) begin
         if (w_hit && (r_stat_hits != '1))    r_stat_hits   <= r_stat_hits + 1'b1;
         if (!w_hit && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 1'b1;
      end
   end

   assign stat_hits   = r_stat_hits;
   assign stat_misses = r_stat_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_cache_core
// Brief    : Directed plus randomized bench for set_assoc_cache_core against a
//            recency-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache_core;

   localparam int WAYS   = 4;
   localparam int SETS   = 128;
   localparam int LINE_W = 256;
   localparam int TAG_W  = 20;

   localparam logic [1:0] T_READ  = 2'b00;
   localparam logic [1:0] T_WRITE = 2'b01;
   localparam logic [1:0] T_FILL  = 2'b10;
   localparam logic [1:0] T_INVAL = 2'b11;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = 2'b00;
   logic [31:0]       req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic [3:0]        req_byte_en = '0;
   logic [LINE_W-1:0] req_line = '0;
   logic              resp_valid, resp_hit, resp_dirty, resp_lvalid;
   logic [1:0]        resp_way;
   logic [TAG_W-1:0]  resp_tag;
   logic [31:0]       resp_data;
   logic [LINE_W-1:0] resp_line;
`ifdef CACHE_STATS_EN
   logic [31:0]       stat_hits, stat_misses;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model; m_order[s][0] is the most recently used way of set s.
   bit                m_valid [SETS][WAYS];
   bit                m_dirty [SETS][WAYS];
   logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
   logic [LINE_W-1:0] m_line  [SETS][WAYS];
   int                m_order [SETS][WAYS];
   int                m_hits, m_misses;

   set_assoc_cache_core dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_byte_en (req_byte_en),
      .req_line    (req_line),
      .resp_valid  (resp_valid),
      .resp_hit    (resp_hit),
      .resp_way    (resp_way),
      .resp_dirty  (resp_dirty),
      .resp_lvalid (resp_lvalid),
      .resp_tag    (resp_tag),
      .resp_data   (resp_data),
      .resp_line   (resp_line)
`ifdef CACHE_STATS_EN
      ,
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_order[s][w] = w;
         end
      end
      m_hits   = 0;
      m_misses = 0;
   endfunction

   function automatic void model_touch(input int s, input int way);
      int p;
      p = 0;
      for (int i = 0; i < WAYS; i++) if (m_order[s][i] == way) p = i;
      for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
      m_order[s][0] = way;
   endfunction

   function automatic int model_victim(input int s);
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
      return m_order[s][WAYS-1];
   endfunction

   function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] l, input int word,
                                                    input logic [31:0] d, input logic [3:0] be);
      logic [LINE_W-1:0] r;
      r = l;
      for (int b = 0; b < 4; b++) if (be[b]) r[word*32 + b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [31:0] mk_addr(input int tag, input int idx, input int word);
      return (32'(tag) << 12) | (32'(idx) << 5) | (32'(word) << 2);
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [LINE_W-1:0] line);
      int s, word, hw, sel;
      logic [TAG_W-1:0]  t, exp_tag;
      logic [LINE_W-1:0] exp_line;
      bit exp_hit, exp_dirty, exp_lvalid;
      s    = int'(addr[11:5]);
      word = int'(addr[4:2]);
      t    = addr[31:12];
      hw   = -1;
      for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && (m_tag[s][w] == t)) hw = w;
      exp_hit    = (hw >= 0);
      sel        = exp_hit ? hw : model_victim(s);
      exp_dirty  = m_dirty[s][sel];
      exp_lvalid = m_valid[s][sel];
      exp_tag    = m_tag[s][sel];
      exp_line   = m_line[s][sel];

      @(negedge clk);
      check("req_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_op = op; req_addr = addr;
      req_wdata = wdata; req_byte_en = be; req_line = line;
      @(posedge clk); #1;
      req_valid = 1'b0;

      check("resp_valid", resp_valid, 1'b1);
      check("resp_hit", resp_hit, exp_hit);
      check("resp_way", resp_way, LINE_W'(sel));
      check("resp_dirty", resp_dirty, exp_dirty);
      check("resp_lvalid", resp_lvalid, exp_lvalid);
      if (exp_lvalid) begin
         check("resp_tag", resp_tag, exp_tag);
         check("resp_data", resp_data, exp_line[word*32 +: 32]);
         check("resp_line", resp_line, exp_line);
      end

      if (op == T_FILL) begin
         m_line[s][sel]  = (be != 4'b0000) ? merge_line(line, word, wdata, be) : line;
         m_tag[s][sel]   = t;
         m_valid[s][sel] = 1'b1;
         m_dirty[s][sel] = (be != 4'b0000);
         model_touch(s, sel);
      end else if (exp_hit) begin
         if (op == T_WRITE) begin
            m_line[s][sel]  = merge_line(m_line[s][sel], word, wdata, be);
            m_dirty[s][sel] = 1'b1;
         end
         model_touch(s, sel);
      end
      if (op == T_READ || op == T_WRITE) begin
         if (exp_hit) m_hits++;
         else         m_misses++;
      end
`ifdef CACHE_STATS_EN
      check("stat_hits", stat_hits, m_hits);
      check("stat_misses", stat_misses, m_misses);
`endif
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic inval_all();
      int low, pulses;
      @(negedge clk);
      check("inval_ready_before", req_ready, 1'b1);
      req_valid = 1'b1; req_op = T_INVAL;
      @(posedge clk); #1;
      req_valid = 1'b0;
      low = 0;
      pulses = 0;
      for (int i = 0; i < 400 && req_ready !== 1'b1; i++) begin
         low++;
         if (resp_valid === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      if (resp_valid === 1'b1) pulses++;
      check("inval_ready_low_cycles", low, 128);
      check("inval_resp_pulses", pulses, 1);
      check("inval_resp_hit", resp_hit, 1'b0);
      @(posedge clk); #1;
      check("inval_resp_single", resp_valid, 1'b0);
      model_reset();
   endtask

   initial begin
      logic [1:0] op;
      logic [3:0] be;
      int r;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_ready", req_ready, 1'b1);
      check("reset_resp_valid", resp_valid, 1'b0);
      check("reset_resp_hit", resp_hit, 1'b0);
      check("reset_resp_way", resp_way, 2'd0);
      check("reset_resp_lvalid", resp_lvalid, 1'b0);

      issue(T_READ, 32'h0000_1040, 32'h0, 4'h0, '0);
      check("t1_hit", resp_hit, 1'b0);
      check("t1_lvalid", resp_lvalid, 1'b0);
      check("t1_way", resp_way, 2'd0);

      issue(T_FILL, 32'h0000_1040, 32'h0, 4'h0, {8{32'hA5A5_A5A5}});
      issue(T_READ, 32'h0000_1040, 32'h0, 4'h0, '0);
      check("t2_hit", resp_hit, 1'b1);
      check("t2_way", resp_way, 2'd0);
      check("t2_data", resp_data, 32'hA5A5_A5A5);
      check("t2_dirty", resp_dirty, 1'b0);

      issue(T_WRITE, 32'h0000_1044, 32'h1234_5678, 4'b0011, '0);
      issue(T_READ, 32'h0000_1044, 32'h0, 4'h0, '0);
      check("t3_data", resp_data, 32'hA5A5_5678);
      check("t3_dirty", resp_dirty, 1'b1);

      pulse_reset();
      for (int t = 1; t <= 5; t++) issue(T_FILL, mk_addr(t, 2, 0), 32'h0, 4'h0, rand_line());
      check("t4_way", resp_way, 2'd0);
      check("t4_tag", resp_tag, 20'd1);
      check("t4_dirty", resp_dirty, 1'b0);
      issue(T_READ, mk_addr(1, 2, 0), 32'h0, 4'h0, '0);
      check("t4_read_evicted", resp_hit, 1'b0);

      pulse_reset();
      for (int t = 1; t <= 4; t++) issue(T_FILL, mk_addr(t, 5, 0), 32'h0, 4'h0, rand_line());
      issue(T_READ, mk_addr(1, 5, 3), 32'h0, 4'h0, '0);
      issue(T_FILL, mk_addr(9, 5, 0), 32'h0, 4'h0, rand_line());
      check("t5_victim", resp_way, 2'd1);

      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 9);
         op = (r < 4) ? T_READ : (r < 7) ? T_WRITE : T_FILL;
         be = 4'($urandom());
         if (op == T_FILL && $urandom_range(0, 1) == 0) be = 4'h0;
         issue(op, mk_addr($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 7)),
               $urandom(), be, rand_line());
      end

      inval_all();
      for (int i = 0; i < 4; i++) begin
         issue(T_READ, mk_addr($urandom_range(1, 6), $urandom_range(0, 3), 0), 32'h0, 4'h0, '0);
         check("t6_read_miss", resp_hit, 1'b0);
      end

      @(negedge clk);
      req_valid = 1'b1; req_op = T_INVAL;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("midsweep_ready_low", req_ready, 1'b0);
      pulse_reset();
      @(posedge clk); #1;
      check("midsweep_ready_after", req_ready, 1'b1);
      issue(T_READ, mk_addr(1, 2, 0), 32'h0, 4'h0, '0);
      check("midsweep_read_miss", resp_hit, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
